acc_stream_unit: RTL and testbench
==================================

// Module: acc_stream_unit
// PURPOSE
//  Sequential accumulate stage built on the team's 32-bit carry-select adder datapath.
//  Takes a stream of signed operands over a valid/ready handshake and adds or subtracts each one into a running register.
//  Returns the final total with an output handshake.
//  Flags a sticky signed overflow for the run.
//  Sits directly downstream of operand sources and drives the adder's A/B/cin; consumes its sum/cout/of.
// PARAMETERS
//  WIDTH  32  datapath width; adder is 16+16 carry-select, so WIDTH must be 32
//  CNT_W  8   operand-count width; max run length 2**CNT_W-1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      begin a run; sampled in IDLE only
//  len        in   CNT_W  operands in this run; sampled with start
//  in_valid   in   1      operand valid
//  in_ready   out  1      operand accepted when in_valid&in_ready
//  in_data    in   WIDTH  signed operand
//  in_sub     in   1      1: acc-=in_data, 0: acc+=in_data; qualified by handshake
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumed when out_valid&out_ready
//  acc_out    out  WIDTH  accumulator value
//  cout_last  out  1      adder carry-out of last accepted operation
//  ovf        out  1      sticky signed overflow for current run
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, acc_out=0, cnt=0, ovf=0, cout_last=0, in_ready=0, out_valid=0.
//  Reset mid-run aborts the run; partial result is discarded.
//  FSM states:
//   IDLE:  start&len!=0 -> ACCUM; acc=0, cnt=len, ovf=0, cout_last=0.
//          start&len==0 -> DONE with acc=0.
//   ACCUM: in_ready=1. Each handshake computes B'=in_sub?~in_data:in_data, cin=in_sub.
//          acc<=sum, cout_last<=cout, ovf<=ovf|of, cnt<=cnt-1.
//          When a handshake occurs with cnt==1 -> DONE.
//   DONE:  out_valid=1, acc_out stable; out_ready -> IDLE (in_ready stays 0).
//  start outside IDLE is ignored. Back-to-back: out_ready and start in the same cycle go to IDLE only; start is re-sampled next cycle.
//  Latency: one operand per cycle. The sum is registered at the edge of the handshake.
//          out_valid rises the cycle after the last handshake.
//  Arithmetic: two's complement mod 2**WIDTH.
//  of = (acc[31]==B'[31]) & (sum[31]!=acc[31]). cout is unsigned carry/no-borrow.
//  in_ready is a pure state decode: no combinational path from in_valid or out_ready.
// CONFIGURATION
//  ACC_SAT_EN defined: on of, acc saturates to 32'h7FFF_FFFF if acc[31]==0, else to 32'h8000_0000.
//   ovf is still set. Later operands continue from the saturated value.
//  ACC_SAT_EN undefined: acc wraps; ovf is the only indication.
// STRUCTURE
//  Package acc_pkg:
//   state typedef {IDLE,ACCUM,DONE}, ACC_W=32.
//   SAT_MAX=32'h7FFF_FFFF, SAT_MIN=32'h8000_0000.
//  One sub-module acc_addsub: combinational B' invert plus cin select around the 32-bit carry-select adder.
//   Outputs sum/cout/of. All state lives in acc_stream_unit.
// TESTING
//  1. len=3, add 5,7,-2 (no stalls) -> out_valid 4 cycles after start, acc_out=10, ovf=0.
//  2. len=2, add 32'h7FFF_FFFF then 1 -> ovf=1.
//     Without SAT: acc_out=32'h8000_0000; with ACC_SAT_EN: acc_out=32'h7FFF_FFFF.
//  3. len=2, sub 1 from 0 then add 1 -> acc_out=0; cout_last=1 (no borrow on +1).
//  4. len=4 with in_valid toggling every other cycle, out_ready held low 3 cycles
//     -> one accumulate per handshake; acc_out stays stable while out_valid waits.
//  5. start with len=0 -> DONE next cycle, acc_out=0. start asserted in ACCUM -> ignored.
//  6. rst pulse after 2 of 4 operands -> all outputs 0 immediately.
//     A new run of len=1, data=9 then gives acc_out=9, ovf=0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulate stream stage.
package acc_pkg;

  localparam int ACC_W = 32;

  localparam logic [ACC_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [ACC_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturation target follows the sign of the running value before the overflowing add.
  function automatic logic [ACC_W-1:0] sat_value(input logic acc_neg);
    return acc_neg ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/acc_addsub.sv
// Add/subtract wrapper around the 16+16 carry-select adder: a + (sub ? ~b : b) + sub.
module acc_addsub
  import acc_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sub,
  output logic [ACC_W-1:0] sum,
  output logic             cout,
  output logic             of
);

  logic [ACC_W-1:0] b_eff;
  logic [16:0]      lo_sum;
  logic [16:0]      hi_sum0;
  logic [16:0]      hi_sum1;

  assign b_eff = sub ? ~b : b;

  assign lo_sum  = {1'b0, a[15:0]}  + {1'b0, b_eff[15:0]}  + {16'd0, sub};
  // Both upper halves are computed in parallel; the lower carry only selects one.
  assign hi_sum0 = {1'b0, a[31:16]} + {1'b0, b_eff[31:16]};
  assign hi_sum1 = {1'b0, a[31:16]} + {1'b0, b_eff[31:16]} + 17'd1;

  always_comb begin
    sum  = '0;
    cout = 1'b0;
    sum[15:0] = lo_sum[15:0];
    if (lo_sum[16]) begin
      sum[31:16] = hi_sum1[15:0];
      cout       = hi_sum1[16];
    end else begin
      sum[31:16] = hi_sum0[15:0];
      cout       = hi_sum0[16];
    end
  end

  assign of = (a[31] == b_eff[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/acc_stream_unit.sv
// Streaming signed accumulator with valid/ready in and out and sticky overflow.
// Define ACC_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module acc_stream_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             cout_last,
  output logic             ovf,
  output logic             busy
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             cout_q;

  logic             hs;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] acc_next;
  logic             add_cout;
  logic             add_of;

  acc_addsub u_addsub (
    .a    (acc),
    .b    (in_data),
    .sub  (in_sub),
    .sum  (add_sum),
    .cout (add_cout),
    .of   (add_of)
  );

`ifdef ACC_SAT_EN
  assign acc_next = add_of ? sat_value(acc[WIDTH-1]) : add_sum;
`else
  assign acc_next = add_sum;
`endif

  assign hs = in_valid && (state == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (hs && (cnt == CNT_W'(1))) begin
          next_state = DONE;
        end
      end
      DONE: begin
        // start is deliberately ignored here; it is re-sampled once back in IDLE.
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      acc    <= '0;
      cnt    <= len;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
    end else if (hs) begin
      acc    <= acc_next;
      cnt    <= cnt - CNT_W'(1);
      ovf_q  <= ovf_q | add_of;
      cout_q <= add_cout;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign ovf       = ovf_q;
  assign cout_last = cout_q;

endmodule

// File: tb/tb_acc_stream_unit.sv
// Scoreboard bench for acc_stream_unit: directed runs push expected results, a monitor checks them.
module tb_acc_stream_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] acc_out;
  logic        cout_last;
  logic        ovf;
  logic        busy;

  typedef struct packed {
    logic [31:0] acc;
    logic        ovf;
    logic        cout;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  acc_stream_unit #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .cout_last (cout_last),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Compare a data word against its hand-computed value.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Compare a single-bit flag against its hand-computed value.
  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // Queue the result a run is expected to return.
  task automatic expectResult(input logic [31:0] acc, input logic o, input logic c);
    exp_t e;
    e.acc  = acc;
    e.ovf  = o;
    e.cout = c;
    expQ.push_back(e);
  endtask

  // Pulse start for one sampling edge with the given run length.
  task automatic applyStimulus(input logic [7:0] runLen);
    start = 1'b1;
    len   = runLen;
    @(posedge clk);
    #1;
    start = 1'b0;
    len   = 8'd0;
  endtask

  // Hold one operand valid until it is accepted, bounded.
  task automatic sendOperand(input logic [31:0] data, input logic sub);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_sub   = sub;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL operand_accept: got no in_ready expected accept of %h", data);
    end
  endtask

  // Wait (bounded) for out_valid, then step past the consuming edge.
  task automatic waitResult(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got out_valid 0 expected 1", name);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got acc %h expected no result", acc_out);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("result_acc", acc_out, monExp.acc);
        checkFlag("result_ovf", ovf, monExp.ovf);
        checkFlag("result_cout", cout_last, monExp.cout);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_acc", acc_out, 32'd0);
    checkFlag("reset_ovf", ovf, 1'b0);
    checkFlag("reset_cout", cout_last, 1'b0);
    checkFlag("reset_in_ready", in_ready, 1'b0);
    checkFlag("reset_out_valid", out_valid, 1'b0);
    checkFlag("reset_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: 5 + 7 + (-2) = 10, final add of -2 carries out.
    expectResult(32'd10, 1'b0, 1'b1);
    applyStimulus(8'd3);
    checkFlag("t1_in_ready", in_ready, 1'b1);
    checkFlag("t1_busy", busy, 1'b1);
    sendOperand(32'd5, 1'b0);
    sendOperand(32'd7, 1'b0);
    checkFlag("t1_not_done_early", out_valid, 1'b0);
    sendOperand(32'hFFFF_FFFE, 1'b0);
    checkFlag("t1_latency", out_valid, 1'b1);
    checkFlag("t1_in_ready_done", in_ready, 1'b0);
    waitResult("t1");
    checkFlag("t1_idle", busy, 1'b0);

    // Test 2: positive overflow.
`ifdef ACC_SAT_EN
    expectResult(32'h7FFF_FFFF, 1'b1, 1'b0);
`else
    expectResult(32'h8000_0000, 1'b1, 1'b0);
`endif
    applyStimulus(8'd2);
    sendOperand(32'h7FFF_FFFF, 1'b0);
    sendOperand(32'd1, 1'b0);
    waitResult("t2");

    // Test 5a: len=0 goes straight to DONE with cleared flags; start held through DONE is ignored.
    expectResult(32'd0, 1'b0, 1'b0);
    start = 1'b1;
    len   = 8'd0;
    @(posedge clk);
    #1;
    checkFlag("t5_len0_done", out_valid, 1'b1);
    checkFlag("t5_len0_ovf_cleared", ovf, 1'b0);
    @(posedge clk);
    #1;
    checkFlag("t5_b2b_idle", busy, 1'b0);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Test 3: 0 - 1 = -1 (borrow), then -1 + 1 = 0 (carry).
    expectResult(32'd0, 1'b0, 1'b1);
    applyStimulus(8'd2);
    sendOperand(32'd1, 1'b1);
    sendOperand(32'd1, 1'b0);
    waitResult("t3");

    // Test 4: 100 - 30 + (-50) - (-20) = 40 with gaps and a stalled consumer.
    expectResult(32'd40, 1'b0, 1'b0);
    out_ready = 1'b0;
    applyStimulus(8'd4);
    sendOperand(32'd100, 1'b0);
    @(posedge clk); #1;
    sendOperand(32'd30, 1'b1);
    @(posedge clk); #1;
    sendOperand(32'hFFFF_FFCE, 1'b0);
    @(posedge clk); #1;
    sendOperand(32'hFFFF_FFEC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkFlag("t4_hold_valid", out_valid, 1'b1);
      checkOutput("t4_hold_acc", acc_out, 32'd40);
      checkFlag("t4_hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitResult("t4");
    checkFlag("t4_idle", busy, 1'b0);

    // Test 5b: start raised during ACCUM must not restart the run.
    expectResult(32'd7, 1'b0, 1'b0);
    applyStimulus(8'd2);
    sendOperand(32'd3, 1'b0);
    start = 1'b1;
    len   = 8'd5;
    sendOperand(32'd4, 1'b0);
    start = 1'b0;
    len   = 8'd0;
    waitResult("t5b");

    // Test 6: reset after 2 of 4 operands aborts, then a fresh run.
    applyStimulus(8'd4);
    sendOperand(32'hFFFF_FFFF, 1'b0);
    sendOperand(32'hFFFF_FFFF, 1'b0);
    checkOutput("t6_partial_acc", acc_out, 32'hFFFF_FFFE);
    checkFlag("t6_partial_cout", cout_last, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_acc", acc_out, 32'd0);
    checkFlag("t6_rst_cout", cout_last, 1'b0);
    checkFlag("t6_rst_ovf", ovf, 1'b0);
    checkFlag("t6_rst_in_ready", in_ready, 1'b0);
    checkFlag("t6_rst_out_valid", out_valid, 1'b0);
    checkFlag("t6_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    expectResult(32'd9, 1'b0, 1'b0);
    applyStimulus(8'd1);
    sendOperand(32'd9, 1'b0);
    waitResult("t6");

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
